// File: rtl/dft_n.sv
// ----------------------------------------------------------------------------
// dft_n : streaming direct-form DFT over a frame of N real samples.
//
// A frame arrives as N/LANES beats of LANES samples. Once stored, the bins
// bin_lo..bin_hi (ascending) are computed one at a time, LANES complex
// products per cycle, and presented on a valid/ready output port.
//
// Optional feature: define DFT_N_MAG_EN to add out_mag = out_re^2 + out_im^2.
//
// Ports
//   clk        rising-edge clock
//   sreset     synchronous active-high reset
//   samples    packed beat, sample n+i at [(LANES-i)*W-1 -: W]
//   rel        beat valid
//   ready      beat accept (high only while loading)
//   bin_lo     first bin, sampled with the first beat of a frame
//   bin_hi     last bin, sampled with the first beat of a frame
//   out_valid  result valid
//   out_ready  result accept
//   out_bin    bin index of the result
//   out_re     real part, accumulator >>> TW_FRAC
//   out_im     imaginary part, accumulator >>> TW_FRAC
//   busy       frame in progress
//   done       one-cycle pulse with the handshake of the last bin
//   out_mag    (DFT_N_MAG_EN only) squared magnitude of the result
//
// States
//   state   | meaning
//   LOAD    | accepting beats into the sample buffer
//   COMPUTE | accumulating products for bin k, then registering the result
//   EMIT    | holding the result until out_valid && out_ready
// ----------------------------------------------------------------------------
module dft_n #(
    parameter int N       = 64,
    parameter int LANES   = 8,
    parameter int W       = 16,
    parameter int TW_FRAC = 14
) (
    input  logic                         clk,
    input  logic                         sreset,
    input  logic [LANES*W-1:0]           samples,
    input  logic                         rel,
    output logic                         ready,
    input  logic [$clog2(N)-1:0]         bin_lo,
    input  logic [$clog2(N)-1:0]         bin_hi,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(N)-1:0]         out_bin,
    output logic signed [W+$clog2(N):0]  out_re,
    output logic signed [W+$clog2(N):0]  out_im,
    output logic                         busy,
    output logic                         done
`ifdef DFT_N_MAG_EN
    ,
    output logic [2*(W+$clog2(N)+1)-1:0] out_mag
`endif
);

    localparam int LOG2N = $clog2(N);
    localparam int AW    = W + LOG2N + 1;
    localparam int TWW   = TW_FRAC + 2;
    localparam int PW    = W + TWW;
    localparam int ACCW  = W + TW_FRAC + 2 + LOG2N;
    localparam int NB    = N / LANES;
    localparam int BW    = (NB > 1) ? $clog2(NB) : 1;
    localparam int CW    = $clog2(NB + 1);
`ifdef DFT_N_MAG_EN
    localparam int MW    = 2 * AW;
`endif

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        EMIT    = 2'd2
    } state_t;

    // Twiddle value rounded to nearest, evaluated at elaboration only.
    function automatic logic signed [TWW-1:0] twiddle(input int idx, input bit want_sin);
        real ang;
        real v;
        int  r;
        ang = 2.0 * 3.14159265358979323846 * real'(idx) / real'(N);
        v   = (want_sin ? $sin(ang) : $cos(ang)) * real'(1 << TW_FRAC);
        r   = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
        return TWW'(r);
    endfunction

    logic signed [TWW-1:0] cos_rom [N];
    logic signed [TWW-1:0] sin_rom [N];

    for (genvar g = 0; g < N; g++) begin : g_rom
        localparam logic signed [TWW-1:0] COS_V = twiddle(g, 1'b0);
        localparam logic signed [TWW-1:0] SIN_V = twiddle(g, 1'b1);
        assign cos_rom[g] = COS_V;
        assign sin_rom[g] = SIN_V;
    end

    state_t                 state_q;
    logic                   ready_q;
    logic [BW-1:0]          beat_cnt_q;
    logic [CW-1:0]          cnt_q;
    logic [LOG2N-1:0]       k_q;
    logic [LOG2N-1:0]       hi_q;
    logic [LANES*W-1:0]     beat_q [NB];
    logic signed [ACCW-1:0] acc_re_q, acc_im_q;
    logic signed [ACCW-1:0] acc_re_d, acc_im_d;
    logic                   out_valid_q;
    logic [LOG2N-1:0]       out_bin_q;
    logic signed [AW-1:0]   out_re_q, out_im_q;
    logic signed [AW-1:0]   out_re_d, out_im_d;
`ifdef DFT_N_MAG_EN
    logic [MW-1:0]          mag_q, mag_d;
    logic signed [MW-1:0]   sq_re, sq_im;
`endif

    logic [LANES*W-1:0]     beat_sel;
    logic [LOG2N-1:0]       n_idx, tw_idx;
    logic signed [W-1:0]    x_s;
    logic signed [PW-1:0]   p_re, p_im;
    logic signed [ACCW-1:0] s_re, s_im;
    logic                   accept;
    logic                   last_bin;

    assign accept   = rel && ready_q && (state_q == LOAD);
    assign last_bin = (k_q == hi_q);

    // One cycle of LANES products; the twiddle index wraps naturally mod N.
    always_comb begin
        beat_sel = beat_q[cnt_q[BW-1:0]];
        s_re     = '0;
        s_im     = '0;
        n_idx    = '0;
        tw_idx   = '0;
        x_s      = '0;
        p_re     = '0;
        p_im     = '0;
        for (int i = 0; i < LANES; i++) begin
            n_idx  = LOG2N'(int'(cnt_q[BW-1:0]) * LANES + i);
            tw_idx = k_q * n_idx;
            x_s    = beat_sel[(LANES-i)*W-1 -: W];
            p_re   = PW'(x_s) * PW'(cos_rom[tw_idx]);
            p_im   = PW'(x_s) * PW'(sin_rom[tw_idx]);
            s_re   = s_re + ACCW'(p_re);
            s_im   = s_im - ACCW'(p_im);
        end
        // The first cycle of a bin starts from zero instead of the old sum.
        acc_re_d = ((cnt_q == '0) ? '0 : acc_re_q) + s_re;
        acc_im_d = ((cnt_q == '0) ? '0 : acc_im_q) + s_im;
        out_re_d = AW'(acc_re_q >>> TW_FRAC);
        out_im_d = AW'(acc_im_q >>> TW_FRAC);
`ifdef DFT_N_MAG_EN
        sq_re    = MW'(out_re_d) * MW'(out_re_d);
        sq_im    = MW'(out_im_d) * MW'(out_im_d);
        mag_d    = $unsigned(sq_re) + $unsigned(sq_im);
`endif
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            state_q     <= LOAD;
            ready_q     <= 1'b1;
            beat_cnt_q  <= '0;
            cnt_q       <= '0;
            k_q         <= '0;
            hi_q        <= '0;
            acc_re_q    <= '0;
            acc_im_q    <= '0;
            out_valid_q <= 1'b0;
            out_bin_q   <= '0;
            out_re_q    <= '0;
            out_im_q    <= '0;
`ifdef DFT_N_MAG_EN
            mag_q       <= '0;
`endif
        end else begin
            case (state_q)
                LOAD: begin
                    if (accept) begin
                        beat_q[beat_cnt_q] <= samples;
                        if (beat_cnt_q == '0) begin
                            k_q  <= bin_lo;
                            // An inverted range collapses to the single bin bin_lo.
                            hi_q <= (bin_hi < bin_lo) ? bin_lo : bin_hi;
                        end
                        if (beat_cnt_q == BW'(NB - 1)) begin
                            beat_cnt_q <= '0;
                            cnt_q      <= '0;
                            ready_q    <= 1'b0;
                            state_q    <= COMPUTE;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + BW'(1);
                        end
                    end
                end
                COMPUTE: begin
                    // NB accumulate cycles, then one cycle to register the result.
                    if (cnt_q == CW'(NB)) begin
                        out_valid_q <= 1'b1;
                        out_bin_q   <= k_q;
                        out_re_q    <= out_re_d;
                        out_im_q    <= out_im_d;
`ifdef DFT_N_MAG_EN
                        mag_q       <= mag_d;
`endif
                        state_q     <= EMIT;
                    end else begin
                        acc_re_q <= acc_re_d;
                        acc_im_q <= acc_im_d;
                        cnt_q    <= cnt_q + CW'(1);
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (last_bin) begin
                            ready_q <= 1'b1;
                            state_q <= LOAD;
                        end else begin
                            k_q     <= k_q + LOG2N'(1);
                            cnt_q   <= '0;
                            state_q <= COMPUTE;
                        end
                    end
                end
                default: begin
                    state_q <= LOAD;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Control outputs are forced to their idle values while reset is applied.
    assign ready     = ready_q | sreset;
    assign out_valid = out_valid_q & ~sreset;
    assign busy      = ~sreset & ((state_q != LOAD) | (beat_cnt_q != '0));
    assign done      = ~sreset & out_valid_q & out_ready & last_bin;
    assign out_bin   = out_bin_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
`ifdef DFT_N_MAG_EN
    assign out_mag   = mag_q;
`endif

endmodule

// File: tb/tb_dft_n.sv
module tb_dft_n;
    localparam int N       = 64;
    localparam int LANES   = 8;
    localparam int W       = 16;
    localparam int TW_FRAC = 14;
    localparam int LOG2N   = 6;
    localparam int AW      = W + LOG2N + 1;
    localparam int NB      = N / LANES;
    localparam real PI     = 3.14159265358979323846;

    logic                  clk = 1'b0;
    logic                  sreset;
    logic [LANES*W-1:0]    samples;
    logic                  rel;
    logic                  ready;
    logic [LOG2N-1:0]      bin_lo, bin_hi;
    logic                  out_valid;
    logic                  out_ready;
    logic [LOG2N-1:0]      out_bin;
    logic signed [AW-1:0]  out_re, out_im;
    logic                  busy, done;
`ifdef DFT_N_MAG_EN
    logic [2*AW-1:0]       out_mag;
`endif

    dft_n #(.N(N), .LANES(LANES), .W(W), .TW_FRAC(TW_FRAC)) dut (
        .clk(clk), .sreset(sreset), .samples(samples), .rel(rel), .ready(ready),
        .bin_lo(bin_lo), .bin_hi(bin_hi), .out_valid(out_valid), .out_ready(out_ready),
        .out_bin(out_bin), .out_re(out_re), .out_im(out_im), .busy(busy), .done(done)
`ifdef DFT_N_MAG_EN
        , .out_mag(out_mag)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int     bin;
        longint re;
        longint im;
        bit     last;
    } exp_t;

    exp_t   sb[$];
    int     total = 0;
    int     bad = 0;
    int     done_cnt = 0;
    int     hs_cnt = 0;
    int     frame_x [N];
    bit     stall_mode = 0;
    int     stall_cnt = 0;
    bit     prev_stall = 0;
    int     hold_bin;
    longint hold_re, hold_im;

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic longint rnd(input real v);
        return (v >= 0.0) ? longint'($rtoi(v + 0.5)) : -longint'($rtoi(0.5 - v));
    endfunction

    function automatic longint tw(input int idx, input bit want_sin);
        real ang;
        ang = 2.0 * PI * real'(idx) / real'(N);
        return rnd((want_sin ? $sin(ang) : $cos(ang)) * real'(1 << TW_FRAC));
    endfunction

    // Reference: X[k] = sum x[n](cos - j sin) with rounded twiddles, then >>> TW_FRAC.
    task automatic push_expected(input int lo, input int hi);
        int k;
        int last;
        longint ar, ai;
        exp_t e;
        k = lo;
        last = (hi < lo) ? lo : hi;
        while (1) begin
            ar = 0;
            ai = 0;
            for (int n = 0; n < N; n++) begin
                ar += longint'(frame_x[n]) * tw((k * n) % N, 1'b0);
                ai -= longint'(frame_x[n]) * tw((k * n) % N, 1'b1);
            end
            e.bin  = k;
            e.re   = ar >>> TW_FRAC;
            e.im   = ai >>> TW_FRAC;
            e.last = (k == last);
            sb.push_back(e);
            if (k == last) break;
            k++;
        end
    endtask

    // Sends frame_x; returns #1 after the edge that accepts the last beat.
    task automatic send_frame(input int lo, input int hi, input bit gaps);
        int  b;
        int  guard;
        bit  acc;
        push_expected(lo, hi);
        b = 0;
        guard = 0;
        while (b < NB && guard < 1000) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                rel = 1'b0;
                samples = $urandom();
            end else begin
                rel = 1'b1;
                for (int i = 0; i < LANES; i++)
                    samples[(LANES-i)*W-1 -: W] = W'(frame_x[b*LANES+i]);
            end
            bin_lo = LOG2N'(lo);
            bin_hi = LOG2N'(hi);
            @(negedge clk);
            acc = rel && ready;
            @(posedge clk);
            #1;
            if (acc) begin
                b++;
                if (b == 1) chk("busy_after_first_beat", busy, 1);
            end
            guard++;
        end
        rel = 1'b0;
        if (b < NB) chk("load_timeout", b, NB);
    endtask

    task automatic wait_drain(input int budget);
        for (int c = 0; c < budget; c++) begin
            if (sb.size() == 0 && !out_valid) break;
            @(posedge clk);
            #1;
        end
        chk("drain_left", sb.size(), 0);
        chk("ready_after_done", ready, 1);
        chk("busy_after_done", busy, 0);
    endtask

    always begin
        @(posedge clk);
        #1;
        if (!stall_mode) out_ready = 1'b1;
        else if (!out_valid) begin
            out_ready = 1'b0;
            stall_cnt = 0;
        end else if (stall_cnt < 5) begin
            out_ready = 1'b0;
            stall_cnt++;
        end else out_ready = 1'b1;
    end

    always @(negedge clk) begin
        exp_t e;
        if (sreset) prev_stall = 0;
        else begin
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_bin", out_bin, hold_bin);
                chk("stall_re", out_re, hold_re);
                chk("stall_im", out_im, hold_im);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("unexpected_output_bin", out_bin, -1);
                else begin
                    e = sb.pop_front();
                    hs_cnt++;
                    chk("out_bin", out_bin, e.bin);
                    chk("out_re", out_re, e.re);
                    chk("out_im", out_im, e.im);
                    chk("done_at_handshake", done, e.last);
`ifdef DFT_N_MAG_EN
                    chk("out_mag", out_mag, e.re * e.re + e.im * e.im);
`endif
                end
            end else if (done) chk("done_without_handshake", done, 0);
            if (done) done_cnt++;
            prev_stall = out_valid && !out_ready;
            hold_bin = out_bin;
            hold_re = out_re;
            hold_im = out_im;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog expired bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, h0, cyc;
        sreset = 1'b1;
        rel = 1'b0;
        samples = '0;
        bin_lo = '0;
        bin_hi = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        sreset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_out_bin", out_bin, 0);
        chk("rst_out_re", out_re, 0);
        chk("rst_out_im", out_im, 0);

        // DC frame, bins 0..3
        for (int n = 0; n < N; n++) frame_x[n] = 100;
        d0 = done_cnt;
        send_frame(0, 3, 0);
        wait_drain(200);
        chk("dc_done_count", done_cnt - d0, 1);

        // Tone at bin 4, bins 3..5, with first-result latency and ignored rel
        for (int n = 0; n < N; n++)
            frame_x[n] = int'(rnd(256.0 * $cos(2.0 * PI * 4.0 * real'(n) / real'(N))));
        send_frame(3, 5, 0);
        cyc = 0;
        for (int c = 1; c <= 40; c++) begin
            rel = 1'b1;
            samples = {$urandom(), $urandom(), $urandom(), $urandom()};
            @(posedge clk);
            #1;
            if (c == 1) chk("ready_in_compute", ready, 0);
            if (out_valid) begin
                cyc = c;
                break;
            end
        end
        rel = 1'b0;
        chk("first_result_latency", cyc, NB + 1);
        wait_drain(200);

        // Impulse, all bins
        for (int n = 0; n < N; n++) frame_x[n] = (n == 0) ? 1000 : 0;
        d0 = done_cnt;
        h0 = hs_cnt;
        send_frame(0, 63, 0);
        wait_drain(2000);
        chk("impulse_handshakes", hs_cnt - h0, 64);
        chk("impulse_done_count", done_cnt - d0, 1);

        // Tone again with input gaps and output stalls
        for (int n = 0; n < N; n++)
            frame_x[n] = int'(rnd(256.0 * $cos(2.0 * PI * 4.0 * real'(n) / real'(N))));
        stall_mode = 1;
        send_frame(3, 5, 1);
        wait_drain(500);
        stall_mode = 0;

        // Reset in the middle of COMPUTE
        for (int n = 0; n < N; n++) frame_x[n] = 100;
        send_frame(0, 3, 0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        sreset = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        sreset = 1'b0;
        chk("midrst_ready", ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        repeat (12) begin
            @(posedge clk);
            #1;
            if (out_valid) chk("midrst_stray_valid", out_valid, 0);
        end
        d0 = done_cnt;
        send_frame(0, 3, 0);
        wait_drain(200);
        chk("midrst_dc_done_count", done_cnt - d0, 1);

        // Inverted range: single bin 7
        d0 = done_cnt;
        h0 = hs_cnt;
        send_frame(7, 2, 0);
        wait_drain(200);
        chk("inverted_handshakes", hs_cnt - h0, 1);
        chk("inverted_done_count", done_cnt - d0, 1);

        // Random frames and ranges
        for (int f = 0; f < 6; f++) begin
            int lo, hi;
            for (int n = 0; n < N; n++) frame_x[n] = int'($urandom_range(0, 65535)) - 32768;
            lo = $urandom_range(0, 63);
            hi = (lo + $urandom_range(0, 3)) % N;
            if (f == 5) hi = (lo == 0) ? 0 : lo - 1;
            stall_mode = f[0];
            d0 = done_cnt;
            send_frame(lo, hi, f[1]);
            wait_drain(600);
            chk("random_done_count", done_cnt - d0, 1);
        end
        stall_mode = 0;

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
